// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM/WB pipeline register and writeback stage with decode bypass
//
// Purpose:
//   Captures the instruction retiring from the memory stage. Selects the
//   writeback value: ALU result, load data, or the LLB/LHB byte merge.
//   Drives the register file write port. Provides a same-cycle
//   write-to-read bypass for decode, and detects HLT at retirement.
//
// Optional feature macro: RETIRE_CNT_EN
//   Adds the retire_cnt[15:0] output. It counts retired instructions,
//   wraps at 0xFFFF and freezes once halted.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   stall, flush        hold the current WB entry / squash the incoming MEM entry
//   mem_*               instruction fields arriving from the memory stage
//   RdReg1, RdReg2      decode source register IDs checked for bypass
//   DstReg, WriteReg,
//   DstData             register file write port
//   fwdHit1, fwdHit2,
//   fwdData             bypass hits and bypass data
//   halt                sticky halted flag
//   retire_cnt          retired-instruction counter (RETIRE_CNT_EN only)

module mem_wb_stage #(
    parameter int DW = 16,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          flush,
    input  logic          mem_valid,
    input  logic          mem_WriteReg,
    input  logic          mem_MemtoReg,
    input  logic [1:0]    mem_LoadByte,
    input  logic [RW-1:0] mem_DstReg,
    input  logic [DW-1:0] mem_ALUResult,
    input  logic [DW-1:0] mem_MemData,
    input  logic [DW-1:0] mem_OldData,
    input  logic [7:0]    mem_Imm8,
    input  logic          mem_Halt,
    input  logic [RW-1:0] RdReg1,
    input  logic [RW-1:0] RdReg2,
    output logic [RW-1:0] DstReg,
    output logic          WriteReg,
    output logic [DW-1:0] DstData,
    output logic          fwdHit1,
    output logic          fwdHit2,
    output logic [DW-1:0] fwdData,
    output logic          halt
`ifdef RETIRE_CNT_EN
    ,
    output logic [15:0]   retire_cnt
`endif
);

    logic          r_valid;
    logic          r_committed;
    logic          r_halt;
    logic          r_wr;
    logic          r_memtoreg;
    logic [1:0]    r_loadbyte;
    logic [RW-1:0] r_dst;
    logic [DW-1:0] r_alu;
    logic [DW-1:0] r_mem;
    logic [DW-1:0] r_old;
    logic [7:0]    r_imm;
    logic          r_hlt;

    logic          w_retiring;
    logic          w_halt_next;
    logic          w_we;
    logic [DW-1:0] w_data;

    // The entry is presented to the register file on its first cycle only.
    assign w_retiring  = r_valid & ~r_committed;
    // A retiring HLT blocks capture on its own retire edge, so nothing
    // behind it can reach the register file.
    assign w_halt_next = r_halt | (w_retiring & r_hlt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid     <= 1'b0;
            r_committed <= 1'b0;
            r_halt      <= 1'b0;
            r_wr        <= 1'b0;
            r_memtoreg  <= 1'b0;
            r_loadbyte  <= 2'b00;
            r_dst       <= '0;
            r_alu       <= '0;
            r_mem       <= '0;
            r_old       <= '0;
            r_imm       <= '0;
            r_hlt       <= 1'b0;
        end else begin
            r_halt <= w_halt_next;
            // Once an entry has been presented, it must not write again
            // while stall holds it.
            if (w_retiring) begin
                r_committed <= 1'b1;
            end
            if (w_halt_next) begin
                r_valid <= 1'b0;
            end else if (flush) begin
                r_valid <= 1'b0;
            end else if (!stall) begin
                r_valid     <= mem_valid;
                r_committed <= 1'b0;
                r_wr        <= mem_WriteReg;
                r_memtoreg  <= mem_MemtoReg;
                r_loadbyte  <= mem_LoadByte;
                r_dst       <= mem_DstReg;
                r_alu       <= mem_ALUResult;
                r_mem       <= mem_MemData;
                r_old       <= mem_OldData;
                r_imm       <= mem_Imm8;
                r_hlt       <= mem_Halt;
            end
        end
    end

    always_comb begin
        w_data = r_memtoreg ? r_mem : r_alu;
        case (r_loadbyte)
            2'b01:   w_data = {r_old[DW-1:8], r_imm};
            2'b10:   w_data = {r_imm, r_old[7:0]};
            default: w_data = r_memtoreg ? r_mem : r_alu;
        endcase
    end

    // R0 is hard-wired zero, so writes to it never leave the stage.
    assign w_we     = w_retiring & r_wr & (r_dst != '0);

    assign DstReg   = r_dst;
    assign WriteReg = w_we;
    assign DstData  = w_data;
    assign fwdData  = w_data;
    assign fwdHit1  = w_we & (RdReg1 == r_dst);
    assign fwdHit2  = w_we & (RdReg2 == r_dst);
    assign halt     = r_halt;

`ifdef RETIRE_CNT_EN
    logic [15:0] r_retire_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_retire_cnt <= 16'h0000;
        end else if (w_retiring & ~r_halt) begin
            r_retire_cnt <= r_retire_cnt + 16'h0001;
        end
    end

    assign retire_cnt = r_retire_cnt;
`endif

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM/WB pipeline register and writeback stage of the 16-bit pipelined CPU.
- Captures the retiring instruction from the memory stage and selects writeback data: ALU result, load data, or the LLB/LHB byte merge.
- Drives the register file write port (DstReg/WriteReg/DstData).
- Provides a same-cycle write-to-read bypass for decode, because the register file returns the old value on a simultaneous write and read.
- Detects HLT at retirement.

Parameters:
- DW, 16, datapath width
- RW, 4, register index width (16 registers, R0 hard-wired zero)

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- stall  input  1  hold current WB entry; do not capture
- flush  input  1  squash incoming MEM entry
- mem_valid  input  1  MEM stage holds a valid instruction
- mem_WriteReg  input  1  instruction writes a register
- mem_MemtoReg  input  1  select mem_MemData over mem_ALUResult
- mem_LoadByte  input  2  00 none, 01 LLB, 10 LHB, 11 treated as 00
- mem_DstReg  input  RW  destination register
- mem_ALUResult  input  DW  ALU result
- mem_MemData  input  DW  data memory read data
- mem_OldData  input  DW  prior destination value (read in decode) for byte merge
- mem_Imm8  input  8  LLB/LHB immediate
- mem_Halt  input  1  instruction is HLT
- RdReg1, RdReg2  input  RW  decode source register IDs for bypass
- DstReg  output  RW  register file write index
- WriteReg  output  1  register file write enable
- DstData  output  DW  register file write data
- fwdHit1, fwdHit2  output  1  bypass valid for RdReg1/RdReg2
- fwdData  output  DW  bypass data (equals DstData)
- halt  output  1  processor halted, sticky

Behaviour:
- Reset (async, rst=1): valid=0, committed=0, halt=0, all captured fields 0.
  - Consequently WriteReg=0, fwdHit*=0, DstReg=0, DstData=0.
- Capture rule at posedge clk, in priority order:
  1. halt=1: valid<=0, no capture.
  2. flush=1: valid<=0 (flush beats stall).
  3. stall=1: hold all fields.
  4. Otherwise: capture all mem_* fields, valid<=mem_valid, committed<=0.
- committed flag:
  - Set at the end of the first cycle in which WriteReg is high.
  - While stall holds an entry, WriteReg asserts once only; later held cycles show WriteReg=0.
- WriteReg = valid & ~committed & wr & (DstReg != 0). Writes to R0 are suppressed.
- DstData selection, combinational from captured fields:
  - LLB: {OldData[15:8], Imm8}.
  - LHB: {Imm8, OldData[7:0]}.
  - Otherwise: MemtoReg ? MemData : ALUResult.
- Write latency: one cycle from MEM capture to the register file write edge.
- Bypass, combinational, zero latency:
  - fwdHitN = WriteReg & (RdRegN == DstReg).
  - RdRegN == 0 never hits, since WriteReg is already 0 for R0.
  - fwdData = DstData.
- Halt: a valid, uncommitted entry with Halt set causes halt<=1 at the next edge. It also marks that entry committed. halt stays high until rst.
- A flush arriving while a stalled entry is held discards the held entry. This is legal only if the held entry is already committed; the controller guarantees this.
- Reset mid-operation clears the entry immediately (asynchronously). No write is issued.

Optional Feature:
- Macro: RETIRE_CNT_EN.
- When defined:
  - Adds output retire_cnt[15:0].
  - Increments by 1 at each edge where valid & ~committed, counting every retired instruction including non-writing ones and HLT.
  - Wraps 0xFFFF -> 0x0000, frozen once halt=1, reset to 0.
- When undefined: no port, no counter logic.

Test Plan:
- Add retire: mem_valid=1, WriteReg=1, DstReg=3, ALUResult=0x1234, then one clock -> WriteReg=1, DstReg=3, DstData=0x1234 for exactly one cycle.
- LHB merge: LoadByte=10, OldData=0xABCD, Imm8=0x5E, DstReg=7 -> DstData=0x5ECD. With LoadByte=01 -> DstData=0xAB5E.
- Stall hold: capture a load (MemtoReg=1, MemData=0x00FF, DstReg=2), then stall=1 for 3 cycles -> WriteReg high in first cycle only, DstReg/DstData held at 2/0x00FF.
- Bypass and R0: WB writing R5=0x0042 with RdReg1=5, RdReg2=0 -> fwdHit1=1, fwdData=0x0042, fwdHit2=0. With DstReg=0 -> WriteReg=0, no hits.
- Flush priority: stall=1 and flush=1 together with mem_valid=1 -> next cycle valid=0, WriteReg=0.
- Halt and reset: HLT retires -> halt=1 next cycle, later mem_valid entries ignored. With RETIRE_CNT_EN, 4 instructions incl. HLT -> retire_cnt=4. Assert rst mid-cycle -> halt=0, WriteReg=0 immediately.
